// File: rtl/mem_stage_pkg.sv
// Package: mem_stage_pkg
// Purpose: shared types and constants for the memory-access pipeline stage.
//   state_e : two-state handshake FSM (idle / waiting for memory ack)
//   CNT_W   : width of the wait-cycle counter used for the ack timeout
package mem_stage_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   localparam int CNT_W = 8;

endpackage : mem_stage_pkg

// File: rtl/mem_stage.sv
// Module: mem_stage
// Purpose: memory-access pipeline stage. Non-memory instructions pass through
//   with one cycle of latency. Loads and stores issue a single memory request
//   and wait for mem_ack, giving up after TIMEOUT wait cycles. Every accepted
//   instruction produces exactly one valid_out pulse.
// Ports:
//   clock, reset                  - clock and synchronous active-high reset
//   valid_in / ready_in           - upstream handshake (ready only when idle)
//   is_load, is_store             - operation kind (both set means store)
//   instruction, address,
//   write_data                    - upstream payload
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_rdata, mem_ack - memory request interface
//   valid_out, mem_out,
//   address_out, instruction_out,
//   err_out                       - downstream result bundle
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_W  = 20,
   parameter int ADDR_W  = 20,
   parameter int INSTR_W = 20,
   parameter int TIMEOUT = 15
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               valid_in,
   output logic               ready_in,
   input  logic               is_load,
   input  logic               is_store,
   input  logic [INSTR_W-1:0] instruction,
   input  logic [ADDR_W-1:0]  address,
   input  logic [DATA_W-1:0]  write_data,
   output logic               mem_req,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [DATA_W-1:0]  mem_wdata,
   input  logic [DATA_W-1:0]  mem_rdata,
   input  logic               mem_ack,
   output logic               valid_out,
   output logic [DATA_W-1:0]  mem_out,
   output logic [ADDR_W-1:0]  address_out,
   output logic [INSTR_W-1:0] instruction_out,
   output logic               err_out
);

   // The request has been outstanding for TIMEOUT cycles when the counter,
   // which counts completed ack-less wait cycles, sits at TIMEOUT-1.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e               state_q,     state_d;
   logic [CNT_W-1:0]     cnt_q,       cnt_d;
   logic                 mem_req_q,   mem_req_d;
   logic                 mem_we_q,    mem_we_d;
   logic [ADDR_W-1:0]    mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
   logic [INSTR_W-1:0]   instr_cap_q, instr_cap_d;
   logic                 valid_out_q, valid_out_d;
   logic [DATA_W-1:0]    mem_out_q,   mem_out_d;
   logic [ADDR_W-1:0]    addr_out_q,  addr_out_d;
   logic [INSTR_W-1:0]   instr_out_q, instr_out_d;
   logic                 err_q,       err_d;

   // Next-state and next-output logic for the idle/wait handshake FSM.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      instr_cap_d = instr_cap_q;
      valid_out_d = 1'b0;
      mem_out_d   = mem_out_q;
      addr_out_d  = addr_out_q;
      instr_out_d = instr_out_q;
      err_d       = err_q;

      case (state_q)
         ST_IDLE: begin
            if (valid_in && (is_load || is_store)) begin
               // Capture the request; mem_addr/mem_wdata stay frozen until done.
               state_d     = ST_WAIT;
               cnt_d       = {CNT_W{1'b0}};
               mem_req_d   = 1'b1;
               mem_we_d    = is_store;
               mem_addr_d  = address;
               mem_wdata_d = write_data;
               instr_cap_d = instruction;
            end else if (valid_in) begin
               valid_out_d = 1'b1;
               mem_out_d   = {DATA_W{1'b0}};
               err_d       = 1'b0;
               addr_out_d  = address;
               instr_out_d = instruction;
            end else begin
               // Idle with nothing offered; a stray mem_ack is ignored here.
               state_d = ST_IDLE;
            end
         end

         ST_WAIT: begin
            if (mem_ack) begin
               // Ack has priority over a timeout landing on the same cycle.
               state_d     = ST_IDLE;
               cnt_d       = {CNT_W{1'b0}};
               mem_req_d   = 1'b0;
               valid_out_d = 1'b1;
               mem_out_d   = mem_we_q ? {DATA_W{1'b0}} : mem_rdata;
               err_d       = 1'b0;
               addr_out_d  = mem_addr_q;
               instr_out_d = instr_cap_q;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = ST_IDLE;
               cnt_d       = {CNT_W{1'b0}};
               mem_req_d   = 1'b0;
               valid_out_d = 1'b1;
               mem_out_d   = {DATA_W{1'b0}};
               err_d       = 1'b1;
               addr_out_d  = mem_addr_q;
               instr_out_d = instr_cap_q;
            end else begin
               cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end

         default: begin
            state_d   = ST_IDLE;
            cnt_d     = {CNT_W{1'b0}};
            mem_req_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset; reset mid-request
   // drops mem_req and suppresses the pending valid_out.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {ADDR_W{1'b0}};
         mem_wdata_q <= {DATA_W{1'b0}};
         instr_cap_q <= {INSTR_W{1'b0}};
         valid_out_q <= 1'b0;
         mem_out_q   <= {DATA_W{1'b0}};
         addr_out_q  <= {ADDR_W{1'b0}};
         instr_out_q <= {INSTR_W{1'b0}};
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         instr_cap_q <= instr_cap_d;
         valid_out_q <= valid_out_d;
         mem_out_q   <= mem_out_d;
         addr_out_q  <= addr_out_d;
         instr_out_q <= instr_out_d;
         err_q       <= err_d;
      end
   end

   assign ready_in        = (state_q == ST_IDLE);
   assign mem_req         = mem_req_q;
   assign mem_we          = mem_we_q;
   assign mem_addr        = mem_addr_q;
   assign mem_wdata       = mem_wdata_q;
   assign valid_out       = valid_out_q;
   assign mem_out         = mem_out_q;
   assign address_out     = addr_out_q;
   assign instruction_out = instr_out_q;
   assign err_out         = err_q;

endmodule : mem_stage
